button_conditioner_array: RTL
=============================

Name: button_conditioner_array

Overview:
- Parametrised, multi-channel conditioner for raw mechanical push-button inputs on the Mojo board.
- Replaces direct wiring of a raw button pin to logic or LEDs.
- Per channel:
  - synchronises the asynchronous pin into clk;
  - debounces it;
  - produces a clean level, one-cycle press/release pulses, a press-toggled latch and a long-hold pulse.
- Sits between top-level button pins and user logic or the LED bank.

Parameters:
- CHANNELS, 1, number of independent button inputs (>=1).
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a new synchronised value must persist before it is accepted (10 ms at 50 MHz); must be >=1.
- HOLD_CYCLES, 50000000, clk cycles the debounced level must stay pressed before hold_pulse fires (1 s at 50 MHz); 0 disables hold detection.
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inversion is applied before the synchroniser.

Ports:
- clk  input  1  50 MHz system clock.
- rst  input  1  Synchronous, active-high reset.
- btn_raw  input  CHANNELS  Asynchronous raw button pins.
- btn_level  output  CHANNELS  Debounced level, 1 = pressed.
- press_pulse  output  CHANNELS  One-cycle strobe on accepted press.
- release_pulse  output  CHANNELS  One-cycle strobe on accepted release.
- toggle_state  output  CHANNELS  Flips on every accepted press.
- hold_pulse  output  CHANNELS  One-cycle strobe when a press has lasted HOLD_CYCLES.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk only.
- Polarity: p = btn_raw XOR ACTIVE_LOW, applied per channel.
- Synchroniser: two flops, sync1 <= p and sync2 <= sync1. Both flops reset to 0, i.e. "not pressed".
- Debounce, per channel:
  - Registers: state (=btn_level) and counter db_cnt of width $clog2(DEBOUNCE_CYCLES+1).
  - If sync2 == state: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: state <= sync2, db_cnt <= 0 (the "accept" event).
  - Else: db_cnt <= db_cnt+1.
  - Any single-cycle return of sync2 to state restarts the count from 0. A glitch shorter than DEBOUNCE_CYCLES never changes state.
- Latency: if p changes before edge k and then stays stable, sync2 holds it after edge k+1. btn_level changes at edge k+DEBOUNCE_CYCLES+1.
- press_pulse: registered. High for exactly the one cycle following an accept where state goes 0->1, i.e. coincident with the first cycle btn_level=1.
- release_pulse: same rule for state 1->0.
- toggle_state: inverts at the same edge press_pulse is set. Unaffected by release.
- Hold, per channel:
  - Counter hold_cnt of width $clog2(HOLD_CYCLES+1).
  - While btn_level=1: hold_cnt increments each cycle, saturating at HOLD_CYCLES.
  - While btn_level=0: hold_cnt <= 0.
  - hold_pulse is high for one cycle on the edge where hold_cnt transitions HOLD_CYCLES-1 -> HOLD_CYCLES, so the press is counted from the first btn_level=1 cycle.
  - Exactly one hold_pulse per press. Release and re-press re-arms it.
  - HOLD_CYCLES=0: hold_pulse tied 0 and the counter is removed.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset (including mid-debounce or mid-hold): all outputs, sync flops and counters go to 0, and toggle_state goes to 0.
  - A button physically held through reset is re-accepted as a fresh press DEBOUNCE_CYCLES+2 cycles after rst deasserts. It produces press_pulse and a toggle at that point.
- press_pulse and release_pulse are never both high in the same cycle on the same channel.

Test Plan:
- Sim params CHANNELS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=0. Assert ch0 btn_raw=1 before edge 0 -> btn_level[0]=1 and press_pulse[0]=1 for exactly 1 cycle at edge 5; toggle_state[0] 0->1 at edge 5.
- Bounce: ch0 raw pattern 1,1,1,0,1,1,1,1,1 -> counter restarts at the 0; btn_level rises only after the final four consecutive synchronised 1s; exactly one press_pulse.
- Hold: keep ch0 pressed 20 cycles -> hold_pulse[0] fires once, 10 cycles after btn_level rose; release -> release_pulse[0] one cycle, 5 cycles after raw drop; second press/release -> toggle_state[0] back to 0, second hold_pulse only if held >=10 cycles.
- Simultaneous: ch0 and ch1 pressed on the same cycle -> press_pulse=2'b11 in one cycle. Short 3-cycle glitch on ch1 only -> ch1 no change, ch0 unaffected.
- Reset mid-hold: assert rst for 1 cycle with ch0 held at hold_cnt=6 -> all outputs 0 next cycle, no hold_pulse. After rst drops with button still held: press_pulse at 6th edge after deassert, hold_pulse 10 cycles later.
- ACTIVE_LOW=1 instance: raw idle 1 -> no pulses after reset; raw driven 0 for 8 cycles -> btn_level=1 and press_pulse behave as in the first scenario.

Source files
------------

// File: rtl/button_conditioner_array.sv
// Multi-channel push-button conditioner: polarity fix, two-flop synchroniser,
// debounce, press/release strobes, press-toggled latch and long-hold strobe.
module button_conditioner_array #(
    parameter int CHANNELS        = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn_raw,
    output logic [CHANNELS-1:0] btn_level,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] toggle_state,
    output logic [CHANNELS-1:0] hold_pulse
);

    localparam int DB_W   = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

    // Polarity is normalised before the synchroniser so "1 = pressed" everywhere after it.
    logic [CHANNELS-1:0] w_pressed_raw;
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    assign w_pressed_raw = btn_raw ^ {CHANNELS{ACTIVE_LOW}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pressed_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DB_W-1:0] r_db_cnt;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            r_toggle;
        logic            r_hold;
        logic            w_differs;
        logic            w_accept;

        assign w_differs = (r_sync2[g] != r_level);
        assign w_accept  = w_differs && (r_db_cnt == DB_LAST);

        // Strobes are registered alongside the level so they line up with its first new cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_toggle  <= 1'b0;
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                if (!w_differs) begin
                    r_db_cnt <= '0;
                end else if (w_accept) begin
                    r_db_cnt  <= '0;
                    r_level   <= r_sync2[g];
                    r_press   <= r_sync2[g];
                    r_release <= !r_sync2[g];
                    r_toggle  <= r_toggle ^ r_sync2[g];
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end
        end

        if (HOLD_CYCLES > 0) begin : g_hold
            logic [HOLD_W-1:0] r_hold_cnt;

            // Saturating at HOLD_MAX guarantees a single strobe per press.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_hold_cnt <= '0;
                    r_hold     <= 1'b0;
                end else if (!r_level) begin
                    r_hold_cnt <= '0;
                    r_hold     <= 1'b0;
                end else begin
                    r_hold <= (r_hold_cnt == HOLD_PRE);
                    if (r_hold_cnt != HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
            end
        end else begin : g_no_hold
            assign r_hold = 1'b0;
        end

        a_press_release_exclusive : assert property (@(posedge clk) !(r_press && r_release));

        assign btn_level[g]     = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign toggle_state[g]  = r_toggle;
        assign hold_pulse[g]    = r_hold;
    end

endmodule
